// File: rtl/edge_event_if.sv
// edge_event_if: valid/ready event port carrying a channel index and edge type.
interface edge_event_if #(parameter int NUM_CH = 4);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    logic            evt_valid_o;
    logic            evt_ready_i;
    logic [CH_W-1:0] evt_ch_o;
    logic            evt_fall_o;
    modport master (output evt_valid_o, evt_ch_o, evt_fall_o, input evt_ready_i);
    modport slave  (input evt_valid_o, evt_ch_o, evt_fall_o, output evt_ready_i);
endinterface

// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: per-channel rise/fall detection latched as pending events,
// serialised round-robin onto one valid/ready port with sticky overrun flags.
module edge_event_arbiter #(
    parameter int NUM_CH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH-1:0]     a_i,
    input  logic [NUM_CH-1:0]     rise_en_i,
    input  logic [NUM_CH-1:0]     fall_en_i,
    input  logic [NUM_CH-1:0]     ovf_clr_i,
    output logic [2*NUM_CH-1:0]   pending_o,
    output logic [NUM_CH-1:0]     overflow_o,
    edge_event_if.master          evt
);
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int NS   = 2 * NUM_CH;
    localparam int SW   = $clog2(NS);

    logic [NUM_CH-1:0] a_q, a_d, ovf_q, ovf_d, ovf_set;
    logic [NS-1:0]     pend_q, pend_d, det, clr;
    logic [SW-1:0]     rr_q, rr_d, gnt;
    logic [CH_W-1:0]   ch_q, ch_d;
    logic              valid_q, valid_d, fall_q, fall_d;
    logic              load, found, take;

    always_comb begin
        a_d = a_i;
        for (int c = 0; c < NUM_CH; c++) begin
            det[2*c]   = ~a_q[c] &  a_i[c] & rise_en_i[c];
            det[2*c+1] =  a_q[c] & ~a_i[c] & fall_en_i[c];
        end
    end

    // first pending slot at or after rr_q, wrapping
    always_comb begin
        found = 1'b0;
        gnt   = '0;
        for (int i = 0; i < NS; i++) begin
            if (!found && pend_q[(int'(rr_q) + i) % NS]) begin
                found = 1'b1;
                gnt   = SW'((int'(rr_q) + i) % NS);
            end
        end
    end

    always_comb begin
        load    = ~valid_q | evt.evt_ready_i;
        take    = load & found;
        clr     = take ? (NS'(1) << gnt) : '0;
        pend_d  = (pend_q & ~clr) | det;
        for (int c = 0; c < NUM_CH; c++)
            ovf_set[c] = |(det[2*c +: 2] & pend_q[2*c +: 2] & ~clr[2*c +: 2]);
        ovf_d   = (ovf_q & ~ovf_clr_i) | ovf_set;
        valid_d = load ? found : valid_q;
        ch_d    = take ? CH_W'(gnt >> 1) : ch_q;
        fall_d  = take ? gnt[0] : fall_q;
        rr_d    = take ? ((gnt == SW'(NS - 1)) ? '0 : gnt + SW'(1)) : rr_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_q     <= '0;
            pend_q  <= '0;
            ovf_q   <= '0;
            rr_q    <= '0;
            valid_q <= 1'b0;
            ch_q    <= '0;
            fall_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            pend_q  <= pend_d;
            ovf_q   <= ovf_d;
            rr_q    <= rr_d;
            valid_q <= valid_d;
            ch_q    <= ch_d;
            fall_q  <= fall_d;
        end
    end

    assign evt.evt_valid_o = valid_q;
    assign evt.evt_ch_o    = ch_q;
    assign evt.evt_fall_o  = fall_q;
    assign pending_o       = pend_q;
    assign overflow_o      = ovf_q;
endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed vector table plus reset sequences for edge_event_arbiter.
module tb_edge_event_arbiter;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] a_i = '0, rise_en_i = '0, fall_en_i = '0, ovf_clr_i = '0;
    logic [7:0] pending_o;
    logic [3:0] overflow_o;
    int         n_vec = 0, n_err = 0;

    edge_event_if #(.NUM_CH(4)) evt ();

    edge_event_arbiter #(.NUM_CH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .a_i        (a_i),
        .rise_en_i  (rise_en_i),
        .fall_en_i  (fall_en_i),
        .ovf_clr_i  (ovf_clr_i),
        .pending_o  (pending_o),
        .overflow_o (overflow_o),
        .evt        (evt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] a, fe, clr;
        logic       rdy;
        logic       v;
        logic [1:0] ch;
        logic       f;
        logic [7:0] pend;
        logic [3:0] ovf;
    } vec_t;

    localparam int NV = 39;
    vec_t tbl [NV];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] outs();
        return {evt.evt_valid_o, evt.evt_ch_o, evt.evt_fall_o, pending_o, overflow_o};
    endfunction

    initial begin
        int         nev;
        logic [2:0] last;
        //            a       fe      clr     rdy   v     ch     f     pend   ovf
        tbl[0]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h45, 4'h0};
        tbl[1]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h44, 4'h0};
        tbl[2]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0, 8'h40, 4'h0};
        tbl[3]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 8'h00, 4'h0};
        tbl[4]  = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 4'h0};
        tbl[5]  = '{4'b0000, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 4'h0};
        tbl[6]  = '{4'b1001, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 8'h41, 4'h0};
        tbl[7]  = '{4'b1001, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h40, 4'h0};
        tbl[8]  = '{4'b1001, 4'h0, 4'h0, 1'b1, 1'b1, 2'd3, 1'b0, 8'h00, 4'h0};
        tbl[9]  = '{4'b1001, 4'h0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 8'h00, 4'h0};
        tbl[10] = '{4'b1101, 4'hF, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 8'h10, 4'h0};
        tbl[11] = '{4'b1101, 4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 4'h0};
        tbl[12] = '{4'b1101, 4'hF, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 4'h0};
        tbl[13] = '{4'b0000, 4'h0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 4'h0};
        tbl[14] = '{4'b0001, 4'h0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 8'h01, 4'h0};
        tbl[15] = '{4'b0000, 4'h0, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 4'h0};
        tbl[16] = '{4'b0000, 4'h0, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0};
        tbl[17] = '{4'b0010, 4'hF, 4'h0, 1'b0, 1'b0, 2'd0, 1'b0, 8'h04, 4'h0};
        tbl[18] = '{4'b0000, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h08, 4'h0};
        tbl[19] = '{4'b0010, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h0C, 4'h0};
        tbl[20] = '{4'b0000, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h0C, 4'h2};
        tbl[21] = '{4'b0010, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h0C, 4'h2};
        tbl[22] = '{4'b0010, 4'hF, 4'h0, 1'b0, 1'b1, 2'd1, 1'b0, 8'h0C, 4'h2};
        tbl[23] = '{4'b0010, 4'hF, 4'h0, 1'b1, 1'b1, 2'd1, 1'b1, 8'h04, 4'h2};
        tbl[24] = '{4'b0010, 4'hF, 4'h0, 1'b1, 1'b1, 2'd1, 1'b0, 8'h00, 4'h2};
        tbl[25] = '{4'b0010, 4'hF, 4'h0, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'h2};
        tbl[26] = '{4'b0010, 4'hF, 4'h2, 1'b1, 1'b0, 2'd1, 1'b0, 8'h00, 4'h0};
        tbl[27] = '{4'b0110, 4'hF, 4'h0, 1'b0, 1'b0, 2'd1, 1'b0, 8'h10, 4'h0};
        tbl[28] = '{4'b0010, 4'hF, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0, 8'h20, 4'h0};
        tbl[29] = '{4'b0110, 4'hF, 4'h0, 1'b0, 1'b1, 2'd2, 1'b0, 8'h30, 4'h0};
        tbl[30] = '{4'b0010, 4'hF, 4'h4, 1'b0, 1'b1, 2'd2, 1'b0, 8'h30, 4'h4};
        tbl[31] = '{4'b0010, 4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 1'b1, 8'h10, 4'h4};
        tbl[32] = '{4'b0010, 4'hF, 4'h0, 1'b1, 1'b1, 2'd2, 1'b0, 8'h00, 4'h4};
        tbl[33] = '{4'b0010, 4'hF, 4'h4, 1'b1, 1'b0, 2'd2, 1'b0, 8'h00, 4'h0};
        tbl[34] = '{4'b1011, 4'hE, 4'h0, 1'b0, 1'b0, 2'd2, 1'b0, 8'h41, 4'h0};
        tbl[35] = '{4'b1010, 4'h6, 4'h0, 1'b0, 1'b1, 2'd3, 1'b0, 8'h01, 4'h0};
        tbl[36] = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h01, 4'h0};
        tbl[37] = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b1, 2'd0, 1'b0, 8'h00, 4'h0};
        tbl[38] = '{4'b1011, 4'hF, 4'h0, 1'b1, 1'b0, 2'd0, 1'b0, 8'h00, 4'h0};

        evt.evt_ready_i = 1'b1;
        rise_en_i = 4'hF;
        fall_en_i = 4'hF;
        repeat (3) step();
        chk("reset_state", outs(), 16'h0000);
        reset = 1'b1;

        for (int i = 0; i < NV; i++) begin
            a_i             = tbl[i].a;
            fall_en_i       = tbl[i].fe;
            ovf_clr_i       = tbl[i].clr;
            evt.evt_ready_i = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d", i), outs(),
                {tbl[i].v, tbl[i].ch, tbl[i].f, tbl[i].pend, tbl[i].ovf});
        end

        // reset while events are pending and one is presented
        a_i = 4'b0000; fall_en_i = 4'hF; ovf_clr_i = '0; evt.evt_ready_i = 1'b0;
        step();
        chk("pre_rst_pend", {8'h00, pending_o}, 16'h008A);
        step();
        chk("pre_rst_valid", {15'b0, evt.evt_valid_o}, 16'h0001);
        reset = 1'b0;
        a_i = 4'b0001;
        #1;
        chk("async_rst_outs", outs(), 16'h0000);
        repeat (2) step();
        chk("held_rst_outs", outs(), 16'h0000);
        reset = 1'b1;
        evt.evt_ready_i = 1'b1;
        nev = 0;
        last = 3'b111;
        for (int k = 0; k < 8; k++) begin
            step();
            if (k == 0) chk("post_rst_pend", {8'h00, pending_o}, 16'h0001);
            if (evt.evt_valid_o) begin
                nev++;
                last = {evt.evt_ch_o, evt.evt_fall_o};
            end
        end
        chk("post_rst_count", 16'(nev), 16'd1);
        chk("post_rst_event", {13'b0, last}, 16'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
